window_3x3_gen: RTL and testbench

Streaming 3x3 neighbourhood generator that sits directly upstream of `sobel_window`. It accepts a raster-order pixel stream, one word per enabled cycle, and keeps the two previous image lines in internal line buffers. It presents a registered 3x3 window on `p1`..`p9`, plus a qualifying strobe that drives the Sobel stage's `en`. Only windows with a complete neighbourhood are emitted; border centres are never flagged valid.

---
 rtl/window_3x3_gen.sv | 178 +++++++++++++++++
 tb/tb_window_3x3_gen.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/window_3x3_gen.sv
// window_3x3_gen
// Streaming 3x3 neighbourhood generator for a raster-order pixel stream.
// Two shift-register line buffers hold the previous two lines; a 3x3
// register window shifts left on every accepted pixel. Only windows whose
// centre has a full neighbourhood are flagged with out_valid.
//
// Handshake: in_valid qualifies in_pixel/in_sof for one cycle; there is no
// backpressure, so every cycle with in_valid=1 is an accepted pixel, and
// every cycle with out_valid=1 presents a window the consumer must take.
module window_3x3_gen #(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  parameter int WORD_SIZE  = 8,
  localparam int RW = $clog2(IMG_HEIGHT),
  localparam int CW = $clog2(IMG_WIDTH)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 in_valid,
  input  logic                 in_sof,
  input  logic [WORD_SIZE-1:0] in_pixel,
  output logic [WORD_SIZE-1:0] p1,
  output logic [WORD_SIZE-1:0] p2,
  output logic [WORD_SIZE-1:0] p3,
  output logic [WORD_SIZE-1:0] p4,
  output logic [WORD_SIZE-1:0] p5,
  output logic [WORD_SIZE-1:0] p6,
  output logic [WORD_SIZE-1:0] p7,
  output logic [WORD_SIZE-1:0] p8,
  output logic [WORD_SIZE-1:0] p9,
  output logic                 out_valid,
  output logic [RW-1:0]        out_row,
  output logic [CW-1:0]        out_col,
  output logic                 frame_done
);

  localparam logic [RW-1:0] LAST_ROW = RW'(IMG_HEIGHT - 1);
  localparam logic [CW-1:0] LAST_COL = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_TWO  = RW'(2);
  localparam logic [CW-1:0] COL_TWO  = CW'(2);
  localparam logic [RW-1:0] ROW_ONE  = RW'(1);
  localparam logic [CW-1:0] COL_ONE  = CW'(1);

  // Position of the pixel expected next on in_pixel
  logic [RW-1:0] row_q, row_d;
  logic [CW-1:0] col_q, col_d;

  // Position of the pixel on in_pixel this cycle, after in_sof override
  logic [RW-1:0] cur_row;
  logic [CW-1:0] cur_col;

  logic          valid_d;
  logic          done_d;
  logic [RW-1:0] out_row_d;
  logic [CW-1:0] out_col_d;

  // Line buffers: index 0 is the newest pixel, IMG_WIDTH-1 the oldest
  logic [WORD_SIZE-1:0] lb1_q [IMG_WIDTH];
  logic [WORD_SIZE-1:0] lb2_q [IMG_WIDTH];
  logic [WORD_SIZE-1:0] lb1_out;
  logic [WORD_SIZE-1:0] lb2_out;

  // Window registers, row-major
  logic [WORD_SIZE-1:0] p1_q, p2_q, p3_q;
  logic [WORD_SIZE-1:0] p4_q, p5_q, p6_q;
  logic [WORD_SIZE-1:0] p7_q, p8_q, p9_q;
  logic                 out_valid_q;
  logic                 frame_done_q;
  logic [RW-1:0]        out_row_q;
  logic [CW-1:0]        out_col_q;

  assign lb1_out = lb1_q[IMG_WIDTH-1];
  assign lb2_out = lb2_q[IMG_WIDTH-1];

  // Position tracking, validity and frame-end decode for the current pixel
  always_comb begin
    cur_row   = row_q;
    cur_col   = col_q;
    row_d     = row_q;
    col_d     = col_q;
    valid_d   = 1'b0;
    done_d    = 1'b0;
    out_row_d = out_row_q;
    out_col_d = out_col_q;
    if (in_sof) begin
      cur_row = '0;
      cur_col = '0;
    end
    if (in_valid) begin
      if (cur_col == LAST_COL) begin
        col_d = '0;
        row_d = (cur_row == LAST_ROW) ? '0 : cur_row + ROW_ONE;
      end else begin
        col_d = cur_col + COL_ONE;
        row_d = cur_row;
      end
      valid_d = (cur_row >= ROW_TWO) && (cur_col >= COL_TWO);
      done_d  = (cur_row == LAST_ROW) && (cur_col == LAST_COL);
      if (valid_d) begin
        out_row_d = cur_row - ROW_ONE;
        out_col_d = cur_col - COL_ONE;
      end
    end
  end

  // Position counters
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      row_q <= '0;
      col_q <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
    end
  end

  // Line-buffer delay lines; contents are never reset since validity gating hides them
  always_ff @(posedge clk) begin
    if (in_valid) begin
      lb1_q[0] <= in_pixel;
      lb2_q[0] <= lb1_out;
      for (int i = 1; i < IMG_WIDTH; i++) begin
        lb1_q[i] <= lb1_q[i-1];
        lb2_q[i] <= lb2_q[i-1];
      end
    end
  end

  // Window shift and registered status outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      p1_q         <= '0;
      p2_q         <= '0;
      p3_q         <= '0;
      p4_q         <= '0;
      p5_q         <= '0;
      p6_q         <= '0;
      p7_q         <= '0;
      p8_q         <= '0;
      p9_q         <= '0;
      out_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      out_row_q    <= '0;
      out_col_q    <= '0;
    end else begin
      out_valid_q  <= valid_d;
      frame_done_q <= done_d;
      out_row_q    <= out_row_d;
      out_col_q    <= out_col_d;
      if (in_valid) begin
        p1_q <= p2_q;
        p2_q <= p3_q;
        p3_q <= lb2_out;
        p4_q <= p5_q;
        p5_q <= p6_q;
        p6_q <= lb1_out;
        p7_q <= p8_q;
        p8_q <= p9_q;
        p9_q <= in_pixel;
      end
    end
  end

  assign p1         = p1_q;
  assign p2         = p2_q;
  assign p3         = p3_q;
  assign p4         = p4_q;
  assign p5         = p5_q;
  assign p6         = p6_q;
  assign p7         = p7_q;
  assign p8         = p8_q;
  assign p9         = p9_q;
  assign out_valid  = out_valid_q;
  assign frame_done = frame_done_q;
  assign out_row    = out_row_q;
  assign out_col    = out_col_q;

endmodule

// File: tb/tb_window_3x3_gen.sv
// Testbench for window_3x3_gen on a 4x4 frame of 8-bit pixels.
module tb_window_3x3_gen;

  localparam int W  = 4;
  localparam int H  = 4;
  localparam int WS = 8;
  localparam int EW = 9 * WS + 2 + 2 + 1;

  // ---------------- clock / reset ----------------
  logic clk;
  logic reset_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic          in_valid;
  logic          in_sof;
  logic [WS-1:0] in_pixel;
  logic [WS-1:0] p1, p2, p3, p4, p5, p6, p7, p8, p9;
  logic          out_valid;
  logic [1:0]    out_row;
  logic [1:0]    out_col;
  logic          frame_done;

  window_3x3_gen #(
    .IMG_WIDTH (W),
    .IMG_HEIGHT(H),
    .WORD_SIZE (WS)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_sof    (in_sof),
    .in_pixel  (in_pixel),
    .p1        (p1),
    .p2        (p2),
    .p3        (p3),
    .p4        (p4),
    .p5        (p5),
    .p6        (p6),
    .p7        (p7),
    .p8        (p8),
    .p9        (p9),
    .out_valid (out_valid),
    .out_row   (out_row),
    .out_col   (out_col),
    .frame_done(frame_done)
  );

  logic [71:0] win;
  assign win = {p1, p2, p3, p4, p5, p6, p7, p8, p9};

  // ---------------- scoreboard ----------------
  logic [EW-1:0] exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;
  int n_win   = 0;

  // Hand-computed windows for pixel = 16*r + c, centres (1,1),(1,2),(2,1),(2,2)
  logic [71:0] win_tab [4];
  logic [1:0]  row_tab [4];
  logic [1:0]  col_tab [4];

  initial begin
    win_tab[0] = 72'h00_01_02_10_11_12_20_21_22;
    win_tab[1] = 72'h01_02_03_11_12_13_21_22_23;
    win_tab[2] = 72'h10_11_12_20_21_22_30_31_32;
    win_tab[3] = 72'h11_12_13_21_22_23_31_32_33;
    row_tab[0] = 2'd1; col_tab[0] = 2'd1;
    row_tab[1] = 2'd1; col_tab[1] = 2'd2;
    row_tab[2] = 2'd2; col_tab[2] = 2'd1;
    row_tab[3] = 2'd2; col_tab[3] = 2'd2;
  end

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [71:0] add_base(input logic [71:0] w, input logic [7:0] base);
    logic [71:0] r;
    for (int k = 0; k < 9; k++) r[k*8 +: 8] = w[k*8 +: 8] + base;
    return r;
  endfunction

  task automatic push_window(input int idx, input logic [7:0] base);
    exp_q.push_back({add_base(win_tab[idx], base), row_tab[idx], col_tab[idx], (idx == 3)});
  endtask

  task automatic push_frame(input logic [7:0] base);
    for (int i = 0; i < 4; i++) push_window(i, base);
  endtask

  // ---------------- driver ----------------
  task automatic drive_cycle(input logic v, input logic sof, input logic [7:0] pix);
    logic [75:0]   snap;
    logic [EW-1:0] e;
    @(negedge clk);
    in_valid = v;
    in_sof   = sof;
    in_pixel = pix;
    snap     = {win, out_row, out_col};
    @(posedge clk);
    #1;
    if (!reset_n) begin
      check_eq("rst_valid", out_valid, 1'b0);
      check_eq("rst_done", frame_done, 1'b0);
      check_eq("rst_window", win, 72'h0);
      check_eq("rst_centre", {out_row, out_col}, 4'h0);
    end else begin
      if (out_valid) begin
        n_win++;
        if (exp_q.size() == 0) begin
          check_eq("extra_window", out_valid, 1'b0);
        end else begin
          e = exp_q.pop_front();
          check_eq("window", win, e[EW-1:5]);
          check_eq("centre", {out_row, out_col}, e[4:1]);
          check_eq("frame_done", frame_done, e[0]);
        end
      end else begin
        check_eq("done_without_valid", frame_done, 1'b0);
      end
      if (!v) begin
        check_eq("gap_valid", out_valid, 1'b0);
        check_eq("gap_hold", {win, out_row, out_col}, snap);
      end
    end
  endtask

  task automatic send_pixels(input logic [7:0] base, input int count, input logic gapped,
                             input logic sof_first);
    for (int i = 0; i < count; i++) begin
      drive_cycle(1'b1, sof_first && (i == 0), base + 8'(16 * (i / W) + (i % W)));
      if (gapped) drive_cycle(1'b0, 1'b0, 8'($urandom_range(0, 255)));
    end
  endtask

  task automatic end_test(input string tag, input int wins);
    check_eq({tag, "_drained"}, 128'(exp_q.size()), 128'd0);
    check_eq({tag, "_win_count"}, 128'(n_win), 128'(wins));
    exp_q.delete();
    n_win = 0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset_n  = 1'b0;
    in_valid = 1'b0;
    in_sof   = 1'b0;
    in_pixel = '0;

    // Reset values while pixels are offered
    for (int i = 0; i < 3; i++) drive_cycle(1'b1, i == 1, 8'($urandom_range(0, 255)));
    @(negedge clk);
    in_valid = 1'b0;
    reset_n  = 1'b1;

    // Full frame, continuous, no in_sof after reset
    push_frame(8'h00);
    send_pixels(8'h00, W * H, 1'b0, 1'b0);
    end_test("full", 4);

    // Gapped frame 1010...
    push_frame(8'h00);
    send_pixels(8'h00, W * H, 1'b1, 1'b1);
    end_test("gapped", 4);

    // Back-to-back frames, second via counter wrap
    push_frame(8'h00);
    push_frame(8'h80);
    send_pixels(8'h00, W * H, 1'b0, 1'b1);
    send_pixels(8'h80, W * H, 1'b0, 1'b0);
    end_test("b2b", 8);

    // Mid-frame in_sof at position (2,1)
    send_pixels(8'h00, 9, 1'b0, 1'b1);
    push_frame(8'h40);
    send_pixels(8'h40, W * H, 1'b0, 1'b1);
    end_test("midsof", 4);

    // Asynchronous reset while a window is valid
    push_window(0, 8'h00);
    send_pixels(8'h00, 11, 1'b0, 1'b1);
    check_eq("pre_rst_valid", out_valid, 1'b1);
    #3;
    reset_n = 1'b0;
    #1;
    check_eq("async_valid", out_valid, 1'b0);
    check_eq("async_done", frame_done, 1'b0);
    check_eq("async_window", win, 72'h0);
    check_eq("async_centre", {out_row, out_col}, 4'h0);
    drive_cycle(1'b1, 1'b0, 8'($urandom_range(0, 255)));
    @(negedge clk);
    in_valid = 1'b0;
    reset_n  = 1'b1;
    end_test("pre_reset", 1);
    push_frame(8'h00);
    send_pixels(8'h00, W * H, 1'b0, 1'b0);
    end_test("post_reset", 4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
